rx_uart_fifo: RTL and testbench
===============================

# rx_uart_fifo

Parametrised 8N1-and-beyond UART receiver for the serial peripherals. It adds runtime-selectable 5–8 data bits, none/even/odd parity and 1 or 2 stop bits. It also provides an input synchronizer, 3-sample majority-vote bit decisions, framing/parity/break detection per character, and a first-word-fall-through receive FIFO with a sticky overrun flag. It sits between the `rx_pin` pad and the bus-side register block, replacing the single-byte receiver where buffering or error reporting is needed.

## Interface
- `FIFO_DEPTH`, 16, receive FIFO entries; power of two, ≥2.
- `SYNC_STAGES`, 2, flops on `rx_pin` before use; ≥2.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset; one clock domain.
- `baud_div`  in  16  bit period minus one, in clocks; valid range ≥4.
- `cfg_data_bits`  in  2  data bits minus 5 (0=5 … 3=8).
- `cfg_parity`  in  2  00 none, 01 even, 10 odd, 11 none.
- `cfg_stop2`  in  1  1 = two stop bits.
- `rx_pin`  in  1  asynchronous serial input, idle high.
- `rx_read`  in  1  pop FIFO head when `rx_valid`.
- `err_clr`  in  1  clears `overrun`.
- `rx_valid`  out  1  FIFO not empty.
- `rx_byte`  out  8  head data, LSB = first bit received, unused upper bits 0.
- `rx_err`  out  3  head flags {break, framing, parity}.
- `rx_count`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `overrun`  out  1  sticky: a character was dropped because the FIFO was full.

## Operation
- Synchronizer flops reset to 1. `rxs` = synchronized pin.
- Bit timer counts down and reloads to `baud_div`, so one bit = `baud_div`+1 clocks.
- Bit value = majority of `rxs` at timer = 2, 1, 0.
- `cfg_*` and `baud_div` are latched on start detection. Changes mid-frame affect only the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH.
  - IDLE: `rxs`=0 → START, timer = `baud_div`>>1.
  - START: at timer 0, majority 1 → IDLE (glitch, nothing pushed). Majority 0 → DATA, timer = `baud_div`.
  - DATA: shift in N = `cfg_data_bits`+5 bits. → PARITY if parity is enabled, else STOP1.
  - PARITY: capture bit. Parity error if even: XOR(data, p)≠0; if odd: XOR(data, p)≠1.
  - STOP1: sample. If 2 stop bits → STOP2, else the frame completes.
  - STOP2: sample; the frame completes.
- Frame completion pushes {break, framing, parity, data}.
  - framing = any stop sample 0.
  - break = all data bits 0, parity bit 0 (if present) and STOP1 sample 0; implies framing.
  - After completion: STOP1 sample 0 → WAIT_HIGH; otherwise → IDLE. Default state → IDLE.
  - STOP2 low sets framing but does not enter WAIT_HIGH.
- WAIT_HIGH: stays until `rxs`=1, then → IDLE. A held-low line yields exactly one break entry.
- FIFO: first-word-fall-through; head is valid whenever `rx_valid`=1.
  - `rx_read` with `rx_valid`=0 is ignored.
  - Push while full without a same-cycle pop: character dropped, `overrun` set.
  - Push and pop in the same cycle while full: both occur, count unchanged, no overrun.
  - Push and pop in the same cycle while empty: not possible, because a pop needs `rx_valid`.
  - Pointers wrap modulo `FIFO_DEPTH`.
- `overrun` clears on `err_clr`. If `err_clr` coincides with a new overrun, set wins.

## Timing
- Reset values: `rx_valid`=0, `rx_byte`=0, `rx_err`=0, `rx_count`=0, `overrun`=0, FSM=IDLE, FIFO empty.
- Reset mid-frame aborts the frame; the partial character is never pushed.
- Start detect: `SYNC_STAGES`+1 clocks after the `rx_pin` falling edge.
- Push happens in the cycle the final stop sample is taken (timer=0). `rx_valid` and `rx_count` update on the next clock.
- Pop: `rx_read`=1 at edge k; the next head, or `rx_valid`=0, is visible after edge k.
- Earliest next start detect: the cycle after the final stop sample. Back-to-back frames are received without gaps.

## Test plan
- `baud_div`=9, 8N1, send 0x55 then 0xA3 back-to-back → two entries 0x55, 0xA3, `rx_err`=0, `rx_count`=2.
- 7E2, send 0x41 with correct parity, then 0x41 with flipped parity bit → first entry err=000, second err=001, data 0x41 both.
- 5N1, send 0x1F with stop bit driven low → entry 0x1F, err=010; no new start until the line returns high.
- Hold `rx_pin` low for 30 bit times, then release → exactly one entry 0x00, err=110, then normal reception resumes.
- `FIFO_DEPTH`=4: send 5 characters without reading → `rx_count`=4, `overrun`=1, 5th lost. `err_clr` clears it. Simultaneous push+pop at full keeps count 4, `overrun` stays 0.
- 1-clock low glitch on an idle line → returns to IDLE, nothing pushed. Assert `rst` mid-DATA → all outputs at reset values, no entry after release.

Source files
------------

// File: rtl/rx_uart_fifo.sv
// UART receiver: runtime-configurable 5-8 data bits, parity and stop bits, majority-vote
// sampling, per-character error flags and a first-word-fall-through receive FIFO.
module rx_uart_fifo #(
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [15:0]                   baud_div,
   input  logic [1:0]                    cfg_data_bits,
   input  logic [1:0]                    cfg_parity,
   input  logic                          cfg_stop2,
   input  logic                          rx_pin,
   input  logic                          rx_read,
   input  logic                          err_clr,
   output logic                          rx_valid,
   output logic [7:0]                    rx_byte,
   output logic [2:0]                    rx_err,
   output logic [$clog2(FIFO_DEPTH):0]   rx_count,
   output logic                          overrun
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH} state_t;

   typedef struct packed {
      logic       brk;
      logic       frm;
      logic       par;
      logic [7:0] data;
   } entry_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxs;

   state_t      state_q, state_d;
   logic [15:0] timer_q, div_q;
   logic [1:0]  bits_q, par_q;
   logic        stop2_q;
   logic        s2_q, s1_q;
   logic [7:0]  data_q;
   logic [2:0]  bit_cnt_q;
   logic        pbit_q, stop1_q;

   logic        tick, maj, par_en, last_bit, zero_frame, par_err;
   logic        push_c, frm_c, brk_c;
   entry_t      push_entry;

   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] count_q;
   logic          valid_q;
   logic          pop, full, do_push;
   entry_t        mem [FIFO_DEPTH];
   entry_t        head;

   // Input synchronizer, idle-high
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_q <= '1;
      else      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_pin};
   end
   assign rxs = sync_q[SYNC_STAGES-1];

   assign tick       = (timer_q == 16'd0);
   assign maj        = (s2_q & s1_q) | (s2_q & rxs) | (s1_q & rxs);
   assign par_en     = (par_q == 2'b01) || (par_q == 2'b10);
   assign last_bit   = (bit_cnt_q == (3'(bits_q) + 3'd4));
   assign zero_frame = (data_q == 8'd0) && !(par_en && pbit_q);
   assign par_err    = par_en && ((^data_q) ^ pbit_q ^ (par_q == 2'b10));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next state and frame-completion push
   always_comb begin
      state_d = state_q;
      push_c  = 1'b0;
      frm_c   = 1'b0;
      brk_c   = 1'b0;
      case (state_q)
         IDLE:   if (!rxs) state_d = START;
         START:  if (tick) state_d = maj ? IDLE : DATA;
         DATA:   if (tick && last_bit) state_d = par_en ? PARITY : STOP1;
         PARITY: if (tick) state_d = STOP1;
         STOP1: begin
            if (tick) begin
               if (stop2_q) begin
                  state_d = STOP2;
               end else begin
                  push_c  = 1'b1;
                  frm_c   = !maj;
                  brk_c   = zero_frame && !maj;
                  state_d = maj ? IDLE : WAIT_HIGH;
               end
            end
         end
         STOP2: begin
            if (tick) begin
               push_c  = 1'b1;
               frm_c   = !stop1_q || !maj;
               brk_c   = zero_frame && !stop1_q;
               state_d = stop1_q ? IDLE : WAIT_HIGH;
            end
         end
         WAIT_HIGH: if (rxs) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   assign push_entry = '{brk: brk_c, frm: frm_c, par: par_err, data: data_q};

   // Bit timer, configuration latch and sample capture
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         timer_q   <= 16'd0;
         div_q     <= 16'd0;
         bits_q    <= 2'd0;
         par_q     <= 2'd0;
         stop2_q   <= 1'b0;
         s2_q      <= 1'b1;
         s1_q      <= 1'b1;
         data_q    <= 8'd0;
         bit_cnt_q <= 3'd0;
         pbit_q    <= 1'b0;
         stop1_q   <= 1'b1;
      end else if (state_q == IDLE && !rxs) begin
         timer_q   <= baud_div >> 1;
         div_q     <= baud_div;
         bits_q    <= cfg_data_bits;
         par_q     <= cfg_parity;
         stop2_q   <= cfg_stop2;
         data_q    <= 8'd0;
         bit_cnt_q <= 3'd0;
      end else if (state_q inside {START, DATA, PARITY, STOP1, STOP2}) begin
         timer_q <= tick ? div_q : timer_q - 16'd1;
         if (timer_q == 16'd2) s2_q <= rxs;
         if (timer_q == 16'd1) s1_q <= rxs;
         if (tick) begin
            case (state_q)
               DATA: begin
                  data_q[bit_cnt_q] <= maj;
                  bit_cnt_q         <= bit_cnt_q + 3'd1;
               end
               PARITY:  pbit_q  <= maj;
               STOP1:   stop1_q <= maj;
               default: ;
            endcase
         end
      end
   end

   assign pop     = rx_read && valid_q;
   assign full    = (count_q == CW'(FIFO_DEPTH));
   assign do_push = push_c && (!full || pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_q] <= push_entry;
   end

   // FIFO pointers, occupancy and sticky overrun; a new overrun beats err_clr
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (pop)     rd_q <= rd_q + AW'(1);
         case ({do_push, pop})
            2'b10: begin
               count_q <= count_q + CW'(1);
               valid_q <= 1'b1;
            end
            2'b01: begin
               count_q <= count_q - CW'(1);
               valid_q <= (count_q != CW'(1));
            end
            default: ;
         endcase
         if (push_c && full && !pop) overrun <= 1'b1;
         else if (err_clr)           overrun <= 1'b0;
      end
   end

   assign head     = mem[rd_q];
   assign rx_valid = valid_q;
   assign rx_byte  = valid_q ? head.data : 8'd0;
   assign rx_err   = valid_q ? {head.brk, head.frm, head.par} : 3'd0;
   assign rx_count = count_q;

endmodule

// File: tb/tb_rx_uart_fifo.sv
// Self-checking bench for rx_uart_fifo: vector table of frames plus hand-written
// sequences for count, break, glitch, overrun and mid-frame reset.
module tb_rx_uart_fifo;

   localparam int DEPTH = 4;
   localparam int BD    = 9;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] baud_div;
   logic [1:0]  cfg_data_bits;
   logic [1:0]  cfg_parity;
   logic        cfg_stop2;
   logic        rx_pin;
   logic        rx_read;
   logic        err_clr;
   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic [2:0]  rx_err;
   logic [2:0]  rx_count;
   logic        overrun;

   logic auto_rd = 1'b0;
   logic man_rd  = 1'b0;
   bit   auto_read = 1'b0;

   assign rx_read = auto_rd | man_rd;

   rx_uart_fifo #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .baud_div(baud_div), .cfg_data_bits(cfg_data_bits),
      .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .rx_pin(rx_pin), .rx_read(rx_read),
      .err_clr(err_clr), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_err(rx_err),
      .rx_count(rx_count), .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] byte_v;
      logic [2:0] err;
   } exp_t;

   typedef struct {
      logic [7:0] data;
      logic [1:0] bits;
      logic [1:0] par;
      logic       stop2;
      logic       flip;
      logic [1:0] stop_low;
      logic [7:0] exp_byte;
      logic [2:0] exp_err;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[13];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard consumer: pops one head per cycle while auto reading is enabled
   always @(negedge clk) begin
      exp_t e;
      auto_rd = 1'b0;
      if (auto_read && rx_valid) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_entry actual=%0h/%b expected=none", rx_byte, rx_err);
         end else begin
            e = sb.pop_front();
            check("head_byte", 32'(rx_byte), 32'(e.byte_v));
            check("head_err", 32'(rx_err), 32'(e.err));
         end
         auto_rd = 1'b1;
      end
   end

   task automatic idle(input int n);
      rx_pin = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Drives one frame starting at the current negedge; cut truncates, pop_at pulses rx_read
   task automatic send_frame(input logic [7:0] d, input logic [1:0] bits, input logic [1:0] par,
                             input logic s2, input logic flip, input logic [1:0] stop_low,
                             input int cut, input int pop_at);
      int   n;
      logic p;
      logic pe;
      logic seq[$];
      exp_t e;
      n  = int'(bits) + 5;
      pe = (par == 2'b01) || (par == 2'b10);
      p  = (par == 2'b10);
      seq.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
         seq.push_back(d[i]);
         p = p ^ d[i];
      end
      if (pe) seq.push_back(p ^ flip);
      seq.push_back(!stop_low[0]);
      if (s2) seq.push_back(!stop_low[1]);
      cfg_data_bits = bits;
      cfg_parity    = par;
      cfg_stop2     = s2;
      for (int c = 0; c < seq.size() * (BD + 1); c++) begin
         if (cut != 0 && c == cut) return;
         rx_pin = seq[c / (BD + 1)];
         man_rd = 1'b0;
         if (pop_at != 0 && c == pop_at) begin
            man_rd = 1'b1;
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL manual_pop actual=%0h expected=none", rx_byte);
            end else begin
               e = sb.pop_front();
               check("pop_byte", 32'(rx_byte), 32'(e.byte_v));
            end
         end
         @(negedge clk);
      end
      man_rd = 1'b0;
      if (stop_low[0]) begin
         rx_pin = 1'b0;
         repeat (2 * (BD + 1)) @(negedge clk);
      end
      if (stop_low != 2'b00) idle(2 * (BD + 1));
   endtask

   task automatic push_exp(input logic [7:0] b, input logic [2:0] e);
      exp_t x;
      x.byte_v = b;
      x.err    = e;
      sb.push_back(x);
   endtask

   task automatic drain(input string name);
      int t;
      auto_read = 1'b1;
      t = 0;
      while ((sb.size() != 0 || rx_valid) && t < 500) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      check(name, 32'(sb.size()), 32'd0);
      check({name, "_count"}, 32'(rx_count), 32'd0);
   endtask

   task automatic check_reset_values(input string name);
      check({name, "_valid"}, 32'(rx_valid), 32'd0);
      check({name, "_byte"}, 32'(rx_byte), 32'd0);
      check({name, "_err"}, 32'(rx_err), 32'd0);
      check({name, "_count"}, 32'(rx_count), 32'd0);
      check({name, "_overrun"}, 32'(overrun), 32'd0);
   endtask

   initial begin
      vecs[0]  = '{8'h55, 2'd3, 2'b00, 1'b0, 1'b0, 2'b00, 8'h55, 3'b000};
      vecs[1]  = '{8'hA3, 2'd3, 2'b00, 1'b0, 1'b0, 2'b00, 8'hA3, 3'b000};
      vecs[2]  = '{8'h41, 2'd2, 2'b01, 1'b1, 1'b0, 2'b00, 8'h41, 3'b000};
      vecs[3]  = '{8'h41, 2'd2, 2'b01, 1'b1, 1'b1, 2'b00, 8'h41, 3'b001};
      vecs[4]  = '{8'h1F, 2'd0, 2'b00, 1'b0, 1'b0, 2'b01, 8'h1F, 3'b010};
      vecs[5]  = '{8'h2A, 2'd1, 2'b10, 1'b0, 1'b0, 2'b00, 8'h2A, 3'b000};
      vecs[6]  = '{8'h00, 2'd3, 2'b10, 1'b0, 1'b0, 2'b01, 8'h00, 3'b010};
      vecs[7]  = '{8'hFF, 2'd3, 2'b01, 1'b0, 1'b0, 2'b00, 8'hFF, 3'b000};
      vecs[8]  = '{8'h00, 2'd0, 2'b00, 1'b1, 1'b0, 2'b11, 8'h00, 3'b110};
      vecs[9]  = '{8'h80, 2'd3, 2'b00, 1'b1, 1'b0, 2'b00, 8'h80, 3'b000};
      vecs[10] = '{8'h7F, 2'd2, 2'b00, 1'b1, 1'b0, 2'b10, 8'h7F, 3'b010};
      vecs[11] = '{8'hE7, 2'd0, 2'b01, 1'b0, 1'b0, 2'b00, 8'h07, 3'b000};
      vecs[12] = '{8'hC3, 2'd1, 2'b11, 1'b0, 1'b0, 2'b00, 8'h03, 3'b000};

      rst           = 1'b0;
      baud_div      = 16'(BD);
      cfg_data_bits = 2'd3;
      cfg_parity    = 2'b00;
      cfg_stop2     = 1'b0;
      rx_pin        = 1'b1;
      err_clr       = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b1;
      idle(5);

      // Back-to-back 8N1 with nothing read: two entries pending
      send_frame(8'h55, 2'd3, 2'b00, 1'b0, 1'b0, 2'b00, 0, 0);
      send_frame(8'hA3, 2'd3, 2'b00, 1'b0, 1'b0, 2'b00, 0, 0);
      idle(5);
      check("b2b_count", 32'(rx_count), 32'd2);
      check("b2b_valid", 32'(rx_valid), 32'd1);
      push_exp(8'h55, 3'b000);
      push_exp(8'hA3, 3'b000);
      drain("b2b_drain");

      // Vector table, frames sent back-to-back while the consumer drains
      foreach (vecs[i]) begin
         push_exp(vecs[i].exp_byte, vecs[i].exp_err);
         send_frame(vecs[i].data, vecs[i].bits, vecs[i].par, vecs[i].stop2, vecs[i].flip,
                    vecs[i].stop_low, 0, 0);
      end
      idle(5);
      drain("table_drain");

      // Line held low for 30 bit times: one break entry, then normal reception
      push_exp(8'h00, 3'b110);
      cfg_data_bits = 2'd3;
      cfg_parity    = 2'b00;
      cfg_stop2     = 1'b0;
      rx_pin = 1'b0;
      repeat (30 * (BD + 1)) @(negedge clk);
      idle(3 * (BD + 1));
      push_exp(8'h3C, 3'b000);
      send_frame(8'h3C, 2'd3, 2'b00, 1'b0, 1'b0, 2'b00, 0, 0);
      idle(5);
      drain("break_drain");

      // One-clock glitch on an idle line
      auto_read = 1'b0;
      @(negedge clk);
      rx_pin = 1'b0;
      @(negedge clk);
      idle(100);
      check("glitch_count", 32'(rx_count), 32'd0);
      check("glitch_valid", 32'(rx_valid), 32'd0);

      // Overflow: five characters into a four-deep FIFO
      for (int k = 1; k <= 5; k++) begin
         if (k <= 4) push_exp(8'(k), 3'b000);
         send_frame(8'(k), 2'd3, 2'b00, 1'b0, 1'b0, 2'b00, 0, 0);
      end
      idle(5);
      check("ovf_count", 32'(rx_count), 32'd4);
      check("ovf_flag", 32'(overrun), 32'd1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      @(negedge clk);
      check("ovf_clear", 32'(overrun), 32'd0);

      // Push and pop in the same cycle while full
      push_exp(8'h06, 3'b000);
      send_frame(8'h06, 2'd3, 2'b00, 1'b0, 1'b0, 2'b00, 0, 3 + BD / 2 + 9 * (BD + 1));
      idle(5);
      check("full_pp_count", 32'(rx_count), 32'd4);
      check("full_pp_overrun", 32'(overrun), 32'd0);
      drain("full_pp_drain");

      // Reset in the middle of the data bits
      auto_read = 1'b0;
      send_frame(8'h77, 2'd3, 2'b00, 1'b0, 1'b0, 2'b00, 0, 0);
      idle(5);
      check("pre_rst_count", 32'(rx_count), 32'd1);
      send_frame(8'h5A, 2'd3, 2'b00, 1'b0, 1'b0, 2'b00, 40, 0);
      rst    = 1'b0;
      rx_pin = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_values("mid_rst");
      rst = 1'b1;
      idle(150);
      check("post_rst_count", 32'(rx_count), 32'd0);
      check("post_rst_valid", 32'(rx_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
